// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM states, default width and counter sizing for the serial adder
package serial_arith_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Counter must hold 0..WIDTH-1 with one spare bit of headroom.
  function automatic int cnt_bits(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: combinational one-bit adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one result bit per cycle through a single full-adder cell
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_bits(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;
  logic             last;

  full_adder u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (c_q),
    .sum (fa_s),
    .cout(fa_c)
  );

  assign last = cnt_q == CW'(WIDTH - 1);
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;

  // Next state: shift one bit per SHIFT cycle, publish the result only when entering DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (state_q == SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = fa_c;
      res_d = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        sum_d   = res_d;
        cout_d  = fa_c;
      end
    end else if (start) begin
      state_d = SHIFT;
      a_d     = a;
      b_d     = b;
      res_d   = '0;
      c_d     = 1'b0;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end

  // State and datapath registers with synchronous reset that discards any partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, start1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       busy8, done8, cout8, busy1, done1, cout1;
  logic [8:0] prev8 = '0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] exp;
    int n, t;
    exp = {1'b0, x} + {1'b0, y};
    a8 = x; b8 = y; start8 = 1'b1;
    tick();
    start8 = 1'b0; n = 0; t = 0;
    while (done8 !== 1'b1 && t < 20) begin
      if (busy8 === 1'b1) n++;
      chk("hold8", {cout8, sum8}, prev8);
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick(); t++;
    end
    chk("busy8", n, 8);
    chk("done8", done8, 1);
    chk("res8", {cout8, sum8}, exp);
    prev8 = exp;
  endtask

  task automatic op1(input logic x, input logic y);
    int n, t;
    a1 = x; b1 = y; start1 = 1'b1;
    tick();
    start1 = 1'b0; n = 0; t = 0;
    while (done1 !== 1'b1 && t < 5) begin
      if (busy1 === 1'b1) n++;
      tick(); t++;
    end
    chk("busy1", n, 1);
    chk("done1", done1, 1);
    chk("res1", {cout1, sum1}, 2'(x) + 2'(y));
  endtask

  initial begin
    logic [7:0] x, y, d;
    int t;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_res8", {cout8, sum8}, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_res1", {cout1, sum1}, 0);
    op8(8'hFF, 8'h01);
    tick();
    chk("idle_done8", done8, 0);
    chk("idle_hold8", {cout8, sum8}, prev8);
    op8(8'hA5, 8'h5A);
    op8(8'h00, 8'h00);
    a8 = 8'h3C; b8 = 8'h0F; start8 = 1'b1;
    tick(); tick(); tick();
    a8 = 8'h11; b8 = 8'h22;
    t = 0;
    while (done8 !== 1'b1 && t < 20) begin tick(); t++; end
    chk("held_res", {cout8, sum8}, 9'h04B);
    tick();
    chk("b2b_busy", busy8, 1);
    start8 = 1'b0; t = 0;
    while (done8 !== 1'b1 && t < 20) begin tick(); t++; end
    chk("b2b_res", {cout8, sum8}, 9'h033);
    prev8 = 9'h033;
    tick();
    a8 = 8'h77; b8 = 8'h99; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    chk("abort_busy_pre", busy8, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_res", {cout8, sum8}, 0);
    t = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 === 1'b1) t++;
      tick();
    end
    chk("abort_nodone", t, 0);
    prev8 = '0;
    op8(8'h80, 8'h80);
    start8 = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; start8 = 1'b0;
    chk("rst_over_start", busy8, 0);
    chk("rst_over_res", {cout8, sum8}, 0);
    prev8 = '0;
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom_range(255));
      y = 8'($urandom_range(255));
      d = x - y;
      op8(x, y);
      op8(d, y);
      chk("roundtrip", sum8, x);
    end
    for (int i = 0; i < 4; i++) op1(i[1], i[0]);
    tick();
    chk("w1_idle_done", done1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
